// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, FSM state encoding and helpers for the nibble-serial adder.
// The adder processes one SLICE_W-bit slice of each operand per clock.
package nibble_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int SLICE_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_sum4bit.sv
// 4-bit ripple-carry adder slice: s = a + b + ci, co = carry out of bit 3.
// Purely combinational; reused once per clock by the serial adder.
module sum4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign co = carry[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder: latches operands on start, adds one nibble per clock
// LSB first through a single 4-bit slice, then reports sum, carry-out and overflow.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int CNT_W = $clog2(NIB);
    localparam int ACC_W = WIDTH - SLICE_W;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] nib_sum;
    logic               nib_co;
    logic [WIDTH-1:0]   nib_full;

    sum4bit u_slice (
        .a  (a_q[SLICE_W-1:0]),
        .b  (b_q[SLICE_W-1:0]),
        .ci (carry_q),
        .s  (nib_sum),
        .co (nib_co)
    );

    // Nibbles completed so far sit in acc_q; the new one lands on top.
    assign nib_full = {nib_sum, acc_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                carry_d = nib_co;
                acc_d   = ACC_W'(nib_full >> SLICE_W);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_NIB) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = nib_full;
                    c_out_d = nib_co;
                    ovf_d   = signed_ovf(a_msb_q, b_msb_q, nib_sum[SLICE_W-1]);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): arithmetic reference model,
// per-cycle monitor of busy/done/result timing and hold behaviour.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c_in = 1'b0;
    logic             busy, done, c_out, ovf;
    logic [WIDTH-1:0] s;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               done_cyc;
    } exp_t;

    exp_t             sb[$];
    int               cyc = 0;
    int               busy_until = 0;
    int               n_chk = 0;
    int               n_fail = 0;
    bit               started = 1'b0;
    logic [WIDTH-1:0] hold_s = '0;
    logic             hold_c = 1'b0;
    logic             hold_o = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: unsigned sum with carry, signed overflow from the integer range.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic ci, input int dcyc);
        exp_t e;
        logic [WIDTH:0] full;
        int ssum;
        full = {1'b0, av} + {1'b0, bv} + (WIDTH+1)'(ci);
        ssum = int'($signed(av)) + int'($signed(bv)) + int'(ci);
        e.s = full[WIDTH-1:0];
        e.c = full[WIDTH];
        e.o = (ssum > 32767) || (ssum < -32768);
        e.done_cyc = dcyc;
        return e;
    endfunction

    // Monitor: done/busy timing, result on done, results held otherwise.
    always @(negedge clk) begin
        if (started && !rst) begin
            logic exp_busy, exp_done;
            exp_t e;
            exp_busy = (sb.size() > 0) && (cyc < sb[0].done_cyc);
            exp_done = (sb.size() > 0) && (cyc == sb[0].done_cyc);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                e = sb.pop_front();
                check("sum", 32'(s), 32'(e.s));
                check("c_out", 32'(c_out), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.o));
                hold_s = e.s;
                hold_c = e.c;
                hold_o = e.o;
            end else begin
                check("hold_s", 32'(s), 32'(hold_s));
                check("hold_c_out", 32'(c_out), 32'(hold_c));
                check("hold_ovf", 32'(ovf), 32'(hold_o));
                if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                    check("done_timeout", 32'(cyc), 32'(sb[0].done_cyc));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        sb.delete();
        hold_s = '0;
        hold_c = 1'b0;
        hold_o = 1'b0;
        busy_until = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic ci);
        int guard = 0;
        while (cyc < busy_until) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 100) begin
                check("idle_wait", 32'(cyc), 32'(busy_until));
                break;
            end
        end
        a = av;
        b = bv;
        c_in = ci;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c_in = 1'($urandom);
        sb.push_back(model(av, bv, ci, cyc + NIB));
        busy_until = cyc + NIB;
    endtask

    task automatic poke_start();
        a = 16'hAAAA;
        b = 16'hAAAA;
        c_in = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [WIDTH-1:0] es,
                                 input logic ec, input logic eo);
        int guard = 0;
        while (cyc < busy_until && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, "_done"}, 32'(done), 32'(1));
        check({name, "_s"}, 32'(s), 32'(es));
        check({name, "_c_out"}, 32'(c_out), 32'(ec));
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_s", 32'(s), 32'(0));
        check("rst_c_out", 32'(c_out), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));

        do_op(16'h1234, 16'h4321, 1'b0);
        expect_result("basic", 16'h5555, 1'b0, 1'b0);

        do_op(16'hFFFF, 16'h0000, 1'b1);
        expect_result("ripple", 16'h0000, 1'b1, 1'b0);

        do_op(16'h7FFF, 16'h0001, 1'b0);
        expect_result("ovf_pos", 16'h8000, 1'b0, 1'b1);

        do_op(16'h8000, 16'h8000, 1'b0);
        expect_result("ovf_neg", 16'h0000, 1'b1, 1'b1);

        do_op(16'h0009, 16'h0004, 1'b0);
        @(posedge clk); #1;
        poke_start();
        expect_result("ignore_busy", 16'h000D, 1'b0, 1'b0);

        @(posedge clk); #1;
        do_op(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        do_reset();
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_s", 32'(s), 32'(0));
        check("abort_c_out", 32'(c_out), 32'(0));
        check("abort_ovf", 32'(ovf), 32'(0));
        repeat (NIB + 2) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'(0));
        end
        do_op(16'h000A, 16'h000B, 1'b1);
        expect_result("after_abort", 16'h0016, 1'b0, 1'b0);

        do_op(16'h0005, 16'h0006, 1'b0);
        expect_result("b2b_first", 16'h000B, 1'b0, 1'b0);
        do_op(16'h0002, 16'h0003, 1'b1);
        check("b2b_hold_s", 32'(s), 32'(16'h000B));
        expect_result("b2b_second", 16'h0006, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                poke_start();
            end
        end

        while (cyc <= busy_until + 2) begin
            @(posedge clk); #1;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
